mac_pe_stw_multi: RTL and testbench

MAC_PE_STW_MULTI -- requirements
Module: mac_pe_stw_multi

---
 rtl/mac_stw_pkg.sv | 21 ++
 rtl/fxp_mul_add.sv | 53 +++++
 rtl/mac_pe_stw_multi.sv | 180 ++++++++++++++++++
 tb/tb_mac_pe_stw_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_stw_pkg.sv
// Shared definitions for the self-testing MAC processing element:
// self-test FSM encoding and the signed saturation rail helper.
package mac_stw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } stw_state_e;

  localparam int unsigned FAIL_CNT_W = 8;

  // Signed rail of a w-bit word: most negative when neg=1, most positive otherwise.
  // Returned 64 bits wide; callers size-cast it down to their word width.
  function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
    logic [63:0] mag;
    mag = (64'd1 << (w - 1)) - 64'd1;
    return neg ? ~mag : mag;
  endfunction

endpackage

// File: rtl/fxp_mul_add.sv
// Fixed-point multiply-add: (op1 * op2) >>> FRAC_BITS, then + addend.
// One instance is shared between normal PE operation and the self-test.
module fxp_mul_add
  import mac_stw_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int SATURATE  = 1
) (
  input  logic [WORD_SIZE-1:0] op1,
  input  logic [WORD_SIZE-1:0] op2,
  input  logic [WORD_SIZE-1:0] addend,
  output logic [WORD_SIZE-1:0] result
);

  localparam int PW = 2 * WORD_SIZE;

  logic signed [WORD_SIZE-1:0] a_s;
  logic signed [WORD_SIZE-1:0] b_s;
  logic signed [PW-1:0]        prod_full;
  logic signed [PW-1:0]        prod_shift;
  logic signed [WORD_SIZE-1:0] prod_w;
  logic signed [WORD_SIZE:0]   sum;

  // The shifted product fits a word when all bits from the word MSB upward agree.
  // In saturating mode an overflowing product pins to the rail instead of wrapping.
  function automatic logic [WORD_SIZE-1:0] clamp_prod(input logic signed [PW-1:0] p);
    if ((p[PW-1:WORD_SIZE-1] == '0) || (p[PW-1:WORD_SIZE-1] == '1))
      return p[WORD_SIZE-1:0];
    return WORD_SIZE'(sat_limit(WORD_SIZE, p[PW-1]));
  endfunction

  // The one-bit-wider sum overflowed when its top two bits disagree.
  function automatic logic [WORD_SIZE-1:0] clamp_sum(input logic signed [WORD_SIZE:0] s);
    if (s[WORD_SIZE] != s[WORD_SIZE-1])
      return WORD_SIZE'(sat_limit(WORD_SIZE, s[WORD_SIZE]));
    return s[WORD_SIZE-1:0];
  endfunction

  // Full-width signed multiply, arithmetic shift, word reduction, widened add.
  always_comb begin
    a_s        = op1;
    b_s        = op2;
    prod_full  = a_s * b_s;
    prod_shift = prod_full >>> FRAC_BITS;
    if (SATURATE != 0) prod_w = clamp_prod(prod_shift);
    else               prod_w = prod_shift[WORD_SIZE-1:0];
    sum = {prod_w[WORD_SIZE-1], prod_w} + {addend[WORD_SIZE-1], addend};
    if (SATURATE != 0) result = clamp_sum(sum);
    else               result = sum[WORD_SIZE-1:0];
  end

endmodule

// File: rtl/mac_pe_stw_multi.sv
// Systolic MAC processing element with built-in self-test: a small vector
// store is replayed through the shared multiply-add while the PE datapath
// holds its state, and pass/fault results are reported afterwards.
module mac_pe_stw_multi
  import mac_stw_pkg::*;
#(
  parameter  int WORD_SIZE  = 16,
  parameter  int FRAC_BITS  = 8,
  parameter  int TEST_DEPTH = 4,
  parameter  int SATURATE   = 1,
  localparam int IDX_W      = (TEST_DEPTH > 1) ? $clog2(TEST_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sys_rst,
  input  logic                  op2_select_in,
  input  logic                  out_select_in,
  input  logic                  stat_bit_in,
  input  logic [WORD_SIZE-1:0]  left_in,
  input  logic [WORD_SIZE-1:0]  top_in,
  output logic [WORD_SIZE-1:0]  right_out,
  output logic [WORD_SIZE-1:0]  bottom_out,
  input  logic                  stw_load_en,
  input  logic [IDX_W-1:0]      stw_load_idx,
  input  logic [WORD_SIZE-1:0]  stw_mult_op1,
  input  logic [WORD_SIZE-1:0]  stw_mult_op2,
  input  logic [WORD_SIZE-1:0]  stw_add_op,
  input  logic [WORD_SIZE-1:0]  stw_expected,
  input  logic                  stw_start,
  output logic                  stw_busy,
  output logic                  stw_done,
  output logic                  stw_pass,
  output logic                  stw_fault,
  output logic [IDX_W-1:0]      stw_fail_idx,
  output logic [FAIL_CNT_W-1:0] stw_fail_count
);

  stw_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] first_fail_q;
  logic             fail_seen_q;

  logic [WORD_SIZE-1:0] vec_op1 [TEST_DEPTH];
  logic [WORD_SIZE-1:0] vec_op2 [TEST_DEPTH];
  logic [WORD_SIZE-1:0] vec_add [TEST_DEPTH];
  logic [WORD_SIZE-1:0] vec_exp [TEST_DEPTH];

  logic [WORD_SIZE-1:0] left_reg, top_reg, stat_reg, acc_reg;
  logic [WORD_SIZE-1:0] mul_a, mul_b, mul_c, mul_r;
  logic                 test_mismatch, last_vec, fail_now, load_ok;

  assign last_vec      = (idx_q == IDX_W'(TEST_DEPTH - 1));
  assign test_mismatch = (mul_r != vec_exp[idx_q]);
  assign fail_now      = fail_seen_q | test_mismatch;
  assign load_ok       = stw_load_en && (state_q == ST_IDLE) &&
                         ({1'b0, stw_load_idx} < (IDX_W + 1)'(TEST_DEPTH));

  assign right_out  = left_reg;
  assign bottom_out = out_select_in ? acc_reg : top_reg;

  // Operand mux: self-test vectors own the multiply-add during RUN.
  always_comb begin
    mul_a = left_reg;
    mul_b = stat_bit_in ? stat_reg : top_reg;
    mul_c = stat_bit_in ? top_reg  : acc_reg;
    if (state_q == ST_RUN) begin
      mul_a = vec_op1[idx_q];
      mul_b = vec_op2[idx_q];
      mul_c = vec_add[idx_q];
    end
  end

  fxp_mul_add #(
    .WORD_SIZE (WORD_SIZE),
    .FRAC_BITS (FRAC_BITS),
    .SATURATE  (SATURATE)
  ) u_mul_add (
    .op1    (mul_a),
    .op2    (mul_b),
    .addend (mul_c),
    .result (mul_r)
  );

  // Next-state and status outputs of the self-test sequencer.
  always_comb begin
    state_d  = state_q;
    stw_busy = 1'b0;
    stw_done = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (stw_start) state_d = ST_RUN;
      ST_RUN: begin
        stw_busy = 1'b1;
        if (last_vec) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        stw_busy = 1'b1;
        stw_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, vector index and result bookkeeping; results land on the REPORT entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      fail_seen_q    <= 1'b0;
      first_fail_q   <= '0;
      stw_pass       <= 1'b1;
      stw_fault      <= 1'b0;
      stw_fail_idx   <= '0;
      stw_fail_count <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (stw_start) begin
            idx_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
          end
        end
        ST_RUN: begin
          if (test_mismatch && !fail_seen_q) begin
            fail_seen_q  <= 1'b1;
            first_fail_q <= idx_q;
          end
          if (last_vec) begin
            stw_pass     <= !fail_now;
            stw_fail_idx <= fail_seen_q ? first_fail_q : (test_mismatch ? idx_q : '0);
            if (fail_now) begin
              stw_fault <= 1'b1;
              if (stw_fail_count != '1) stw_fail_count <= stw_fail_count + 1'b1;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Self-test vector store; writes only land while idle and in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TEST_DEPTH; i++) begin
        vec_op1[i] <= '0;
        vec_op2[i] <= '0;
        vec_add[i] <= '0;
        vec_exp[i] <= '0;
      end
    end else if (load_ok) begin
      vec_op1[stw_load_idx] <= stw_mult_op1;
      vec_op2[stw_load_idx] <= stw_mult_op2;
      vec_add[stw_load_idx] <= stw_add_op;
      vec_exp[stw_load_idx] <= stw_expected;
    end
  end

  // PE datapath: advances only while idle, frozen during a test, cleared by a failing test.
  always_ff @(posedge clk or posedge rst or posedge sys_rst) begin
    if (rst || sys_rst) begin
      left_reg <= '0;
      top_reg  <= '0;
      stat_reg <= '0;
      acc_reg  <= '0;
    end else if (state_q == ST_IDLE) begin
      left_reg <= left_in;
      top_reg  <= top_in;
      if (op2_select_in) stat_reg <= top_in;
      acc_reg  <= mul_r;
    end else if ((state_q == ST_RUN) && last_vec && fail_now) begin
      acc_reg <= '0;
    end
  end

endmodule

// File: tb/tb_mac_pe_stw_multi.sv
// Directed bench for mac_pe_stw_multi: datapath steps scored through a queue
// against a fixed-point reference, plus self-test sequencing scenarios.
module tb_mac_pe_stw_multi;

  localparam int W  = 16;
  localparam int F  = 8;
  localparam int D  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst, sys_rst, op2_select_in, out_select_in, stat_bit_in;
  logic [W-1:0]  left_in, top_in;
  logic          stw_load_en;
  logic [IW-1:0] stw_load_idx;
  logic [W-1:0]  stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected;
  logic          stw_start;

  logic [W-1:0]  right_out, bottom_out;
  logic          stw_busy, stw_done, stw_pass, stw_fault;
  logic [IW-1:0] stw_fail_idx;
  logic [7:0]    stw_fail_count;

  logic [W-1:0]  w_right, w_bottom;
  logic          w_busy, w_done, w_pass, w_fault;
  logic [IW-1:0] w_fail_idx;
  logic [7:0]    w_fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] sb_q [$];
  logic [W-1:0] m_left, m_top, m_stat, m_acc;
  logic [W-1:0] cur_l, cur_t;
  logic         cur_o2, cur_st, cur_os;

  logic [W-1:0] v_a [D] = '{16'h0100, 16'h0300, 16'h7F00, 16'h8000};
  logic [W-1:0] v_b [D] = '{16'h0200, 16'hFF00, 16'h7F00, 16'h0100};
  logic [W-1:0] v_c [D] = '{16'h0080, 16'h0100, 16'h0000, 16'hFF00};

  int busy_n, done_n;

  always #5 clk = ~clk;

  mac_pe_stw_multi #(.WORD_SIZE(W), .FRAC_BITS(F), .TEST_DEPTH(D), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .sys_rst(sys_rst),
    .op2_select_in(op2_select_in), .out_select_in(out_select_in), .stat_bit_in(stat_bit_in),
    .left_in(left_in), .top_in(top_in), .right_out(right_out), .bottom_out(bottom_out),
    .stw_load_en(stw_load_en), .stw_load_idx(stw_load_idx),
    .stw_mult_op1(stw_mult_op1), .stw_mult_op2(stw_mult_op2),
    .stw_add_op(stw_add_op), .stw_expected(stw_expected),
    .stw_start(stw_start), .stw_busy(stw_busy), .stw_done(stw_done),
    .stw_pass(stw_pass), .stw_fault(stw_fault),
    .stw_fail_idx(stw_fail_idx), .stw_fail_count(stw_fail_count)
  );

  mac_pe_stw_multi #(.WORD_SIZE(W), .FRAC_BITS(F), .TEST_DEPTH(D), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .sys_rst(sys_rst),
    .op2_select_in(op2_select_in), .out_select_in(out_select_in), .stat_bit_in(stat_bit_in),
    .left_in(left_in), .top_in(top_in), .right_out(w_right), .bottom_out(w_bottom),
    .stw_load_en(stw_load_en), .stw_load_idx(stw_load_idx),
    .stw_mult_op1(stw_mult_op1), .stw_mult_op2(stw_mult_op2),
    .stw_add_op(stw_add_op), .stw_expected(stw_expected),
    .stw_start(stw_start), .stw_busy(w_busy), .stw_done(w_done),
    .stw_pass(w_pass), .stw_fault(w_fault),
    .stw_fail_idx(w_fail_idx), .stw_fail_count(w_fail_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Q(W-F).F reference: product reduced to a word, then a widened add.
  function automatic logic [W-1:0] fx(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] c, input bit sat);
    longint p, s;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> F;
    if (sat) begin
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
    end else begin
      p = longint'($signed(p[15:0]));
    end
    s = p + longint'($signed(c));
    if (sat) begin
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
    end
    return s[15:0];
  endfunction

  // One idle-datapath clock: predict, push to the scoreboard, clock, pop and compare.
  task automatic step(input string tag, input logic [W-1:0] l, input logic [W-1:0] t,
                      input logic o2, input logic st, input logic os, input logic start);
    logic [W-1:0] op2, add, nacc;
    left_in = l; top_in = t; op2_select_in = o2; stat_bit_in = st;
    out_select_in = os; stw_start = start;
    cur_l = l; cur_t = t; cur_o2 = o2; cur_st = st; cur_os = os;
    op2  = st ? m_stat : m_top;
    add  = st ? m_top  : m_acc;
    nacc = fx(m_left, op2, add, 1'b1);
    m_left = l; m_top = t;
    if (o2) m_stat = t;
    m_acc = nacc;
    sb_q.push_back(os ? nacc : t);
    @(posedge clk); #1;
    stw_start = 1'b0;
    chk({tag, "_right"}, 64'(right_out), 64'(m_left));
    chk({tag, "_bottom"}, 64'(bottom_out), 64'(sb_q.pop_front()));
  endtask

  task automatic load_vec(input logic [IW-1:0] i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] e);
    stw_load_en = 1'b1; stw_load_idx = i;
    stw_mult_op1 = a; stw_mult_op2 = b; stw_add_op = c; stw_expected = e;
    step("load", cur_l, cur_t, cur_o2, cur_st, cur_os, 1'b0);
    stw_load_en = 1'b0;
  endtask

  // Follow a started test to completion, scrambling data inputs to expose a thawed datapath.
  task automatic run_test(input bit inject, output int b_n, output int d_n);
    b_n = stw_busy ? 1 : 0;
    d_n = 0;
    for (int i = 0; i < 20 && stw_busy; i++) begin
      if (inject && b_n == 2) begin
        stw_start = 1'b1; stw_load_en = 1'b1; stw_load_idx = 2'd2;
        stw_mult_op1 = v_a[2]; stw_mult_op2 = v_b[2]; stw_add_op = v_c[2];
        stw_expected = fx(v_a[2], v_b[2], v_c[2], 1'b1);
      end
      left_in = W'($urandom);
      top_in  = W'($urandom);
      @(posedge clk); #1;
      stw_start = 1'b0; stw_load_en = 1'b0;
      if (stw_busy) b_n++;
      if (stw_done) d_n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sys_rst = 1'b0; op2_select_in = 1'b0; out_select_in = 1'b1; stat_bit_in = 1'b0;
    left_in = '0; top_in = '0; stw_load_en = 1'b0; stw_load_idx = '0;
    stw_mult_op1 = '0; stw_mult_op2 = '0; stw_add_op = '0; stw_expected = '0; stw_start = 1'b0;
    cur_l = '0; cur_t = '0; cur_o2 = 1'b0; cur_st = 1'b0; cur_os = 1'b1;
    m_left = '0; m_top = '0; m_stat = '0; m_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bottom", 64'(bottom_out), 64'h0);
    chk("rst_right",  64'(right_out), 64'h0);
    chk("rst_busy",   64'(stw_busy), 64'h0);
    chk("rst_done",   64'(stw_done), 64'h0);
    chk("rst_pass",   64'(stw_pass), 64'h1);
    chk("rst_fault",  64'(stw_fault), 64'h0);
    chk("rst_fidx",   64'(stw_fail_idx), 64'h0);
    chk("rst_fcnt",   64'(stw_fail_count), 64'h0);
    chk("rst_wrap_all", 64'({w_right, w_bottom, w_busy, w_done, w_pass, w_fault,
                             w_fail_idx, w_fail_count}), 64'h800);
    rst = 1'b0;

    for (int i = 0; i < D; i++)
      load_vec(IW'(i), v_a[i], v_b[i], v_c[i], fx(v_a[i], v_b[i], v_c[i], 1'b1));

    // Basic multiply-accumulate, stationary and streaming.
    step("dp_a", 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0);
    step("dp_b", 16'h0200, 16'h0180, 1'b0, 1'b1, 1'b1, 1'b0);
    step("dp_mac", 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mac_0400", 64'(bottom_out), 64'h0400);
    step("dp_top", 16'h0300, 16'hFE80, 1'b0, 1'b0, 1'b0, 1'b0);

    // Product overflow: saturating vs wrapping instance.
    step("sat_a", 16'h7F00, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sat_b", 16'h7F00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sat_p", 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat_7fff", 64'(bottom_out), 64'h7FFF);
    chk("wrap_fe00", 64'(w_bottom), 64'hFE00);

    // Sum overflow at both rails.
    step("sum_pos", 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sum_pos2", 16'h8000, 16'h7F00, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sum_neg", 16'h8000, 16'h7F00, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sum_neg2", 16'h8000, 16'h7F00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("neg_rail", 64'(bottom_out), 64'h8000);

    // Datapath-only clear.
    #2 sys_rst = 1'b1;
    #1;
    chk("sysrst_acc", 64'(bottom_out), 64'h0);
    chk("sysrst_left", 64'(right_out), 64'h0);
    chk("sysrst_pass", 64'(stw_pass), 64'h1);
    sys_rst = 1'b0;
    m_left = '0; m_top = '0; m_stat = '0; m_acc = '0;

    // Passing self-test; datapath must resume with pre-test values.
    step("start1", 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b1);
    run_test(1'b0, busy_n, done_n);
    chk("t1_busy_cycles", 64'(busy_n), 64'd5);
    chk("t1_done_pulses", 64'(done_n), 64'd1);
    chk("t1_pass", 64'(stw_pass), 64'h1);
    chk("t1_fault", 64'(stw_fault), 64'h0);
    chk("t1_fcnt", 64'(stw_fail_count), 64'h0);
    chk("t1_acc_kept", 64'(bottom_out), 64'(m_acc));
    chk("t1_left_kept", 64'(right_out), 64'(m_left));

    // Vector 2 expectation corrupted.
    load_vec(2'd2, v_a[2], v_b[2], v_c[2], fx(v_a[2], v_b[2], v_c[2], 1'b1) ^ 16'h0001);
    step("start2", 16'h0040, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1);
    run_test(1'b0, busy_n, done_n);
    m_acc = '0;
    chk("t2_busy_cycles", 64'(busy_n), 64'd5);
    chk("t2_pass", 64'(stw_pass), 64'h0);
    chk("t2_fidx", 64'(stw_fail_idx), 64'd2);
    chk("t2_fault", 64'(stw_fault), 64'h1);
    chk("t2_fcnt", 64'(stw_fail_count), 64'd1);
    chk("t2_acc_clr", 64'(bottom_out), 64'h0);

    // Start and load during RUN are ignored.
    step("start3", 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1);
    run_test(1'b1, busy_n, done_n);
    m_acc = '0;
    chk("t3_busy_cycles", 64'(busy_n), 64'd5);
    chk("t3_done_pulses", 64'(done_n), 64'd1);
    chk("t3_fcnt", 64'(stw_fail_count), 64'd2);
    chk("t3_fidx", 64'(stw_fail_idx), 64'd2);

    // Start in the first idle cycle launches immediately.
    step("start4", 16'h0200, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_busy_now", 64'(stw_busy), 64'h1);
    run_test(1'b0, busy_n, done_n);
    m_acc = '0;
    chk("t4_busy_cycles", 64'(busy_n), 64'd5);
    chk("t4_fcnt", 64'(stw_fail_count), 64'd3);

    // Reset mid-RUN aborts without a done pulse.
    step("start5", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    left_in = '0; top_in = '0;
    rst = 1'b1;
    #1;
    chk("t5_busy", 64'(stw_busy), 64'h0);
    chk("t5_fault", 64'(stw_fault), 64'h0);
    chk("t5_fcnt", 64'(stw_fail_count), 64'h0);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (stw_done) done_n++;
    end
    chk("t5_no_done", 64'(done_n), 64'd0);
    rst = 1'b0;
    m_left = '0; m_top = '0; m_stat = '0; m_acc = '0;

    // Cleared vectors are self-consistent: test passes.
    step("start6", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_test(1'b0, busy_n, done_n);
    chk("t6_busy_cycles", 64'(busy_n), 64'd5);
    chk("t6_pass", 64'(stw_pass), 64'h1);
    chk("t6_fcnt", 64'(stw_fail_count), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
